// File: rtl/distribution_ram_reader.sv
// rtl/distribution_ram_reader.sv - full-lattice RAM sweep into a 2-deep ready/valid stream
// Optional macro DIST_READER_COORD_EN adds node_x/node_y coordinate outputs.
module distribution_ram_reader #(
    parameter int DEPTH         = 16*16,
    parameter int ADDRESS_WIDTH = $clog2(DEPTH),
    parameter int DATA_WIDTH    = 32*9,
    parameter int LATTICE_X     = 16
) (
    input  logic                          Clk,
    input  logic                          Reset,
    input  logic                          start,
    output logic                          busy,
    output logic                          done,
    output logic [ADDRESS_WIDTH-1:0]      address,
    output logic                          WE,
    input  logic signed [DATA_WIDTH-1:0]  data_out,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic signed [DATA_WIDTH-1:0]  m_data,
    output logic [ADDRESS_WIDTH-1:0]      m_addr,
    output logic                          m_last
`ifdef DIST_READER_COORD_EN
    ,
    output logic [ADDRESS_WIDTH-1:0]      node_x,
    output logic [ADDRESS_WIDTH-1:0]      node_y
`endif
);

    // One extra counter bit so the issue count can reach DEPTH without wrapping.
    localparam int CW = ADDRESS_WIDTH + 1;
    localparam logic [CW-1:0]            LAST_CNT  = CW'(DEPTH - 1);
    localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDR = ADDRESS_WIDTH'(DEPTH - 1);
`ifdef DIST_READER_COORD_EN
    localparam logic [ADDRESS_WIDTH-1:0] LX        = ADDRESS_WIDTH'(LATTICE_X);
`endif

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                        state;
    state_t                        state_nxt;
    logic [CW-1:0]                 rd_cnt;
    logic [ADDRESS_WIDTH-1:0]      addr_hold;
    logic                          inflight;
    logic [ADDRESS_WIDTH-1:0]      inflight_addr;
    logic [1:0]                    count;
    logic                          wr_ptr;
    logic                          rd_ptr;
    logic signed [DATA_WIDTH-1:0]  fifo_data [2];
    logic [ADDRESS_WIDTH-1:0]      fifo_addr [2];
    logic                          fifo_last [2];
`ifdef DIST_READER_COORD_EN
    logic [ADDRESS_WIDTH-1:0]      fifo_x [2];
    logic [ADDRESS_WIDTH-1:0]      fifo_y [2];
`endif
    logic                          push;
    logic                          pop;
    logic                          issue;
    logic                          drained;

    assign pop  = m_valid & m_ready;
    assign push = inflight;

    // Credit check: entries held plus reads still returning, less what leaves this cycle.
    assign issue = (state == S_RUN) &&
                   (({1'b0, count} + {2'b00, inflight}) < (3'd2 + {2'b00, pop}));

    assign drained = !inflight && ((count == 2'd0) || ((count == 2'd1) && pop));

    assign address = issue ? rd_cnt[ADDRESS_WIDTH-1:0] : addr_hold;
    assign WE      = 1'b0;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:  if (start) state_nxt = S_RUN;
            S_RUN:   if (issue && (rd_cnt == LAST_CNT)) state_nxt = S_DRAIN;
            S_DRAIN: if (drained) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        unique case (state)
            S_RUN, S_DRAIN: busy = 1'b1;
            S_DONE:         done = 1'b1;
            default:        ;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            rd_cnt        <= '0;
            addr_hold     <= '0;
            inflight      <= 1'b0;
            inflight_addr <= '0;
        end else begin
            inflight <= issue;
            if ((state == S_IDLE) && start) begin
                rd_cnt <= '0;
            end else if (issue) begin
                rd_cnt <= rd_cnt + CW'(1);
            end
            if (issue) begin
                addr_hold     <= address;
                inflight_addr <= address;
            end
        end
    end

    // Two-entry FIFO: the head only moves on pop, so stalled beats stay stable.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            count  <= 2'd0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                fifo_data[i] <= '0;
                fifo_addr[i] <= '0;
                fifo_last[i] <= 1'b0;
`ifdef DIST_READER_COORD_EN
                fifo_x[i]    <= '0;
                fifo_y[i]    <= '0;
`endif
            end
        end else begin
            if (push) begin
                fifo_data[wr_ptr] <= data_out;
                fifo_addr[wr_ptr] <= inflight_addr;
                fifo_last[wr_ptr] <= (inflight_addr == LAST_ADDR);
`ifdef DIST_READER_COORD_EN
                fifo_x[wr_ptr]    <= inflight_addr % LX;
                fifo_y[wr_ptr]    <= inflight_addr / LX;
`endif
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    assign m_valid = (count != 2'd0);
    assign m_data  = fifo_data[rd_ptr];
    assign m_addr  = fifo_addr[rd_ptr];
    assign m_last  = fifo_last[rd_ptr];
`ifdef DIST_READER_COORD_EN
    assign node_x  = fifo_x[rd_ptr];
    assign node_y  = fifo_y[rd_ptr];
`endif

endmodule

// File: tb/tb_distribution_ram_reader.sv
// tb/tb_distribution_ram_reader.sv - self-checking bench for distribution_ram_reader
module tb_distribution_ram_reader;

    localparam int DEPTH   = 256;
    localparam int AW      = 8;
    localparam int DW      = 288;
    localparam int NEG_IDX = 200;

    logic                 Clk = 1'b0;
    logic                 Reset = 1'b1;
    logic                 start = 1'b0;
    logic                 busy;
    logic                 done;
    logic [AW-1:0]        address;
    logic                 WE;
    logic signed [DW-1:0] data_out;
    logic                 m_valid;
    logic                 m_ready = 1'b0;
    logic signed [DW-1:0] m_data;
    logic [AW-1:0]        m_addr;
    logic                 m_last;
`ifdef DIST_READER_COORD_EN
    logic [AW-1:0]        node_x;
    logic [AW-1:0]        node_y;
`endif

    distribution_ram_reader dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .address  (address),
        .WE       (WE),
        .data_out (data_out),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_data   (m_data),
        .m_addr   (m_addr),
        .m_last   (m_last)
`ifdef DIST_READER_COORD_EN
        ,
        .node_x   (node_x),
        .node_y   (node_y)
`endif
    );

    always #5 Clk = ~Clk;

    int cycle = 0;
    always @(posedge Clk) cycle <= cycle + 1;

    // Lattice memory image: node k holds k in all nine lanes, one node holds -5.
    function automatic logic [DW-1:0] exp_word(input int k);
        logic [31:0] lane;
        lane = (k == NEG_IDX) ? 32'(-5) : k[31:0];
        return {9{lane}};
    endfunction

    logic [DW-1:0] mem [DEPTH];
    initial begin
        for (int k = 0; k < DEPTH; k++) mem[k] = exp_word(k);
    end
    always @(posedge Clk) data_out <= mem[address];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Stream model state: next expected node index plus sweep observations.
    logic          chk_en = 1'b0;
    int            c0 = 0;
    int            exp_idx = 0;
    int            first_valid = -1;
    int            done_rel = -1;
    int            n_done = 0;
    int            n_last = 0;
    logic          stall_prev = 1'b0;
    logic [DW-1:0] held_data;
    logic [AW-1:0] held_addr;
    logic          held_last;

    always @(negedge Clk) begin
        if (chk_en) begin
            if (stall_prev) begin
                check("stall_valid", m_valid, 1'b1);
                check("stall_data", m_data, held_data);
                check("stall_addr", m_addr, held_addr);
                check("stall_last", m_last, held_last);
            end
            if (m_valid && first_valid < 0) first_valid = cycle - c0;
            if (m_valid && m_ready) begin
                check("beat_addr", m_addr, exp_idx);
                check("beat_data", m_data, exp_word(exp_idx));
                check("beat_last", m_last, exp_idx == DEPTH - 1);
                if (exp_idx == 37) check("pin_data_37", m_data[31:0], 32'h0000_0025);
                if (exp_idx == NEG_IDX) check("pin_neg5", m_data[DW-1:DW-32], 32'hFFFF_FFFB);
`ifdef DIST_READER_COORD_EN
                check("node_x", node_x, exp_idx % 16);
                check("node_y", node_y, exp_idx / 16);
                if (exp_idx == 37) begin
                    check("pin_node_x_37", node_x, 8'd5);
                    check("pin_node_y_37", node_y, 8'd2);
                end
`endif
                if (m_last) n_last++;
                exp_idx++;
            end
            if (done) begin
                n_done++;
                if (done_rel < 0) done_rel = cycle - c0;
            end
            stall_prev = m_valid && !m_ready;
            held_data  = m_data;
            held_addr  = m_addr;
            held_last  = m_last;
        end else begin
            stall_prev = 1'b0;
        end
    end

    task automatic begin_sweep();
        exp_idx     = 0;
        first_valid = -1;
        done_rel    = -1;
        n_done      = 0;
        n_last      = 0;
        @(posedge Clk); #1;
        c0     = cycle;
        start  = 1'b1;
        chk_en = 1'b1;
    endtask

    // mode 0: ready held high; 1: ready random 30%; 2: ready low until 10 cycles after first valid
    task automatic run_sweep(input int mode, input bit pulse_extra_start, input int budget);
        int r;
        int gaps;
        logic [AW-1:0] stall_addr;
        gaps = 0;
        stall_addr = '0;
        m_ready = (mode == 0);
        begin_sweep();
        while (n_done == 0) begin
            @(posedge Clk); #1;
            r = cycle - c0;
            start = pulse_extra_start && (r == 50 || r == 259);
            if (mode == 1) m_ready = ($urandom_range(0, 99) < 30);
            if (mode == 2) begin
                m_ready = (first_valid >= 0) && (r >= first_valid + 10);
                if (first_valid >= 0 && r == first_valid + 1) stall_addr = address;
                if (first_valid >= 0 && r == first_valid + 9) begin
                    check("stall_addr_held", address, stall_addr);
                    check("stall_addr_bound", address <= 8'd2, 1'b1);
                end
                if (first_valid >= 0 && r >= first_valid + 10 && exp_idx < DEPTH && !m_valid)
                    gaps++;
            end
            if (mode == 0 && r == 1) begin
                check("addr0_cycle1", address, 8'd0);
                check("busy_cycle1", busy, 1'b1);
            end
            if (r > budget) begin
                check("sweep_timeout", r, budget);
                break;
            end
        end
        repeat (3) begin
            @(posedge Clk); #1;
            start = 1'b0;
        end
        check("beats_total", exp_idx, DEPTH);
        check("single_done", n_done, 1);
        check("single_last", n_last, 1);
        check("idle_after_done", busy, 1'b0);
        if (mode == 0) begin
            check("first_valid_cycle", first_valid, 3);
            check("done_cycle", done_rel, 259);
        end
        if (mode == 2) check("no_gap_after_release", gaps, 0);
        chk_en = 1'b0;
    endtask

    task automatic reset_mid_sweep();
        int r;
        m_ready = 1'b1;
        begin_sweep();
        r = 0;
        while (exp_idx < 100 && r <= 400) begin
            @(posedge Clk); #1;
            start = 1'b0;
            r = cycle - c0;
        end
        check("reached_beat_100", exp_idx >= 100, 1'b1);
        chk_en = 1'b0;
        Reset  = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        check("rst_mid_valid", m_valid, 1'b0);
        check("rst_mid_busy", busy, 1'b0);
        check("rst_mid_done", done, 1'b0);
        Reset = 1'b0;
        repeat (3) begin
            @(negedge Clk);
            check("post_rst_valid", m_valid, 1'b0);
            check("post_rst_busy", busy, 1'b0);
        end
    endtask

    initial begin
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_valid", m_valid, 1'b0);
        check("rst_address", address, 8'd0);
        check("rst_we", WE, 1'b0);
        check("rst_last", m_last, 1'b0);
        Reset = 1'b0;
        @(negedge Clk);
        check("idle_valid", m_valid, 1'b0);
        check("idle_busy", busy, 1'b0);
        check("idle_address", address, 8'd0);

        run_sweep(0, 1'b1, 600);
        run_sweep(2, 1'b0, 800);
        run_sweep(1, 1'b0, 5000);
        reset_mid_sweep();
        run_sweep(0, 1'b0, 600);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/distribution_ram_reader.md
DISTRIBUTION_RAM_READER -- requirements
Module: distribution_ram_reader

Interface
REQ-001 SHALL have parameter DEPTH, default 16*16: number of lattice nodes (RAM entries).
REQ-002 SHALL have parameter ADDRESS_WIDTH, default $clog2(DEPTH): RAM address width.
REQ-003 SHALL have parameter DATA_WIDTH, default 32*9: one D2Q9 distribution vector, signed.
REQ-004 SHALL have parameter LATTICE_X, default 16: nodes per lattice row.
REQ-005 Clk  input  1  sole clock, rising edge.
REQ-006 Reset  input  1  synchronous, active-high reset.
REQ-007 start  input  1  begin one full-lattice sweep; sampled only in IDLE.
REQ-008 busy  output  1  high in RUN and DRAIN.
REQ-009 done  output  1  one-cycle pulse at sweep completion.
REQ-010 address  output  ADDRESS_WIDTH  RAM address.
REQ-011 WE  output  1  RAM write enable; constant 0.
REQ-012 data_out  input  DATA_WIDTH signed  RAM read data, valid one cycle after address.
REQ-013 m_valid  output  1  stream beat valid.
REQ-014 m_ready  input  1  downstream accepts beat.
REQ-015 m_data  output  DATA_WIDTH signed  distribution vector of current beat.
REQ-016 m_addr  output  ADDRESS_WIDTH  node index of current beat.
REQ-017 m_last  output  1  high on beat with m_addr = DEPTH-1.

Function
REQ-018 FSM states IDLE, RUN, DRAIN, DONE; IDLE->RUN on start; RUN->DRAIN after issuing address DEPTH-1; DRAIN->DONE when buffer empty and no read in flight; DONE->IDLE unconditionally after one cycle.
REQ-019 done SHALL be high exactly in DONE; start in DONE or busy SHALL be ignored.
REQ-020 Read issue counter SHALL start at 0 on RUN entry, increment by 1 per issued read, never wrap within a sweep.
REQ-021 A read issues in a RUN cycle only if (buffer occupancy + in-flight reads - pop this cycle) < 2; address holds its value when not issuing.
REQ-022 Returned data SHALL be written, with its node index, into a 2-entry FIFO one cycle after issue; FIFO SHALL never overflow.
REQ-023 m_valid = FIFO non-empty; m_data/m_addr/m_last = FIFO head; pop on m_valid & m_ready.
REQ-024 m_data, m_addr, m_last SHALL stay stable while m_valid & !m_ready.
REQ-025 Beats SHALL emerge in strictly ascending node order 0..DEPTH-1, each exactly once.
REQ-026 With start at cycle 0 and m_ready held high: address 0 driven in cycle 1, first m_valid in cycle 3, one beat per cycle thereafter, done in the cycle after the m_last handshake.
REQ-027 Simultaneous push and pop at full occupancy SHALL be legal and keep occupancy at 2.

Reset
REQ-028 Reset SHALL force IDLE, FIFO empty, no read in flight, counter 0.
REQ-029 Outputs during/after reset: busy=0, done=0, m_valid=0, address=0, WE=0, m_last=0.
REQ-030 Reset mid-sweep SHALL abort immediately; in-flight RAM data the next cycle SHALL be discarded.

Configuration
REQ-031 Macro DIST_READER_COORD_EN: when defined, outputs node_x (m_addr mod LATTICE_X) and node_y (m_addr / LATTICE_X), width ADDRESS_WIDTH each, registered alongside FIFO head, reset 0.
REQ-032 Without DIST_READER_COORD_EN those ports and their logic SHALL not exist; all other behaviour identical.

Verification
REQ-033 Start, m_ready=1, DEPTH=256 -> 256 beats, m_addr 0..255 contiguous, first m_valid cycle 3, m_last only at 255, done at cycle 259.
REQ-034 Preload mem[k] = k replicated in all 9 lanes -> every m_data matches mem[m_addr] bit-exact, including signed negative preload -5.
REQ-035 m_ready toggled random 30% duty -> no lost/duplicated beat, stability held during stalls, occupancy never >2.
REQ-036 m_ready=0 for 10 cycles after first m_valid -> address advances at most 2 reads past 0, then holds; release -> resumes without gap.
REQ-037 Reset asserted at beat 100 -> next cycle m_valid=0, busy=0; new start -> sweep restarts at m_addr 0.
REQ-038 With DIST_READER_COORD_EN, m_addr=37, LATTICE_X=16 -> node_x=5, node_y=2; start pulsed while busy -> ignored, single done.
